// File: rtl/nv_nvdla_sdp_core_gather.sv
// Narrow-to-wide gatherer: packs RATIO IW-bit beats (segment 0 at the LSBs) into one OW-bit word.
// Optional flush/partial-word support is enabled by defining NVDLA_SDP_GATHER_FLUSH_EN.
module nv_nvdla_sdp_core_gather #(
   parameter int IW    = 128,
   parameter int OW    = 512,
   parameter int RATIO = OW / IW
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rst,
   input  logic          inp_pvld,
   output logic          inp_prdy,
   input  logic [IW-1:0] inp_data,
   output logic          out_pvld,
   input  logic          out_prdy,
   output logic [OW-1:0] out_data,
   output logic          gather_busy
`ifdef NVDLA_SDP_GATHER_FLUSH_EN
   ,
   input  logic             inp_flush,
   output logic [RATIO-1:0] out_mask
`endif
);

   localparam logic [3:0] LAST_SEG = 4'(RATIO - 1);

   generate
      if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8 || RATIO == 16) ||
          (OW != RATIO * IW)) begin : g_badRatio
         $error("nv_nvdla_sdp_core_gather: RATIO must be 1/2/4/8/16 and OW must equal RATIO*IW");
      end
   endgenerate

   logic [3:0]    r_segCnt;
   logic          r_outPvld;
   logic [OW-1:0] r_outData;
   logic          r_gatherBusy;
   logic [OW-1:0] w_accPad;
   logic [OW-1:0] w_nextWord;
   logic          w_flush;
   logic          w_lastBeat;
   logic          w_inpAcc;
   logic          w_outAcc;
   logic          w_inpPrdy;

`ifdef NVDLA_SDP_GATHER_FLUSH_EN
   logic [RATIO-1:0] r_outMask;
   logic [RATIO-1:0] w_nextMask;
   assign w_flush  = inp_flush;
   assign out_mask = r_outMask;
`else
   assign w_flush = 1'b0;
`endif

   assign w_lastBeat  = (r_segCnt == LAST_SEG) | w_flush;
   assign w_inpPrdy   = !w_lastBeat | !r_outPvld | out_prdy;
   assign w_inpAcc    = inp_pvld & w_inpPrdy;
   assign w_outAcc    = r_outPvld & out_prdy;
   assign inp_prdy    = w_inpPrdy;
   assign out_pvld    = r_outPvld;
   assign out_data    = r_outData;
   assign gather_busy = r_gatherBusy;

   generate
      if (RATIO > 1) begin : g_acc
         logic [(RATIO-1)*IW-1:0] r_accData;

         // Partial-word storage is deliberately never reset or cleared; seg_cnt alone tracks validity.
         always_ff @(posedge nvdla_core_clk) begin
            if (w_inpAcc && !w_lastBeat) begin
               for (int s = 0; s < RATIO - 1; s++) begin
                  if (r_segCnt == 4'(s)) begin
                     r_accData[s*IW +: IW] <= inp_data;
                  end
               end
            end
         end

         assign w_accPad = {{IW{1'b0}}, r_accData};
      end else begin : g_noAcc
         assign w_accPad = '0;
      end
   endgenerate

   // Assemble the outgoing word: stored segments below, current beat in place, zeros above.
   always_comb begin
      w_nextWord = '0;
      for (int s = 0; s < RATIO; s++) begin
         if (4'(s) < r_segCnt) begin
            w_nextWord[s*IW +: IW] = w_accPad[s*IW +: IW];
         end else if (4'(s) == r_segCnt) begin
            w_nextWord[s*IW +: IW] = inp_data;
         end
      end
   end

`ifdef NVDLA_SDP_GATHER_FLUSH_EN
   always_comb begin
      w_nextMask = '0;
      for (int s = 0; s < RATIO; s++) begin
         w_nextMask[s] = (4'(s) <= r_segCnt);
      end
   end
`endif

   // A drain and a last-beat load in the same cycle keep out_pvld high with no bubble.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         r_segCnt     <= '0;
         r_outPvld    <= 1'b0;
         r_outData    <= '0;
         r_gatherBusy <= 1'b0;
`ifdef NVDLA_SDP_GATHER_FLUSH_EN
         r_outMask    <= '0;
`endif
      end else begin
         if (w_outAcc) begin
            r_outPvld <= 1'b0;
         end
         if (w_inpAcc) begin
            if (w_lastBeat) begin
               r_outData    <= w_nextWord;
               r_outPvld    <= 1'b1;
               r_segCnt     <= '0;
               r_gatherBusy <= 1'b0;
`ifdef NVDLA_SDP_GATHER_FLUSH_EN
               r_outMask    <= w_nextMask;
`endif
            end else begin
               r_segCnt     <= r_segCnt + 4'd1;
               r_gatherBusy <= 1'b1;
            end
         end
      end
   end

endmodule
